// File: rtl/fp_normalize.sv
// Normalization stage of the FP adder: right-shifts on carry-out, otherwise
// left-shifts the significand at most STEP bits per cycle until the hidden bit is set.
module fp_normalize #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S_IN,
  input  logic [7:0]  E_IN,
  input  logic [27:0] M_SUM,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        S,
  output logic [7:0]  E_NORM,
  output logic [26:0] M_NORM,
  output logic        ZERO,
  output logic        OVF,
  output logic        UNF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state;
  state_t      state_next;
  logic [26:0] m;
  logic [7:0]  e;

  logic [7:0]  e_eff;
  logic [8:0]  e_inc;
  logic        in_zero;
  logic        in_carry;
  logic [26:0] m_carry;

  logic [4:0]  lz;
  logic [4:0]  k;
  logic [7:0]  e_m1;
  logic [26:0] m_sh;
  logic [7:0]  e_sh;
  logic        shift_exit;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc = 5'(26 - i);
    end
  endfunction

  // Classify the incoming operand; an all-ones exponent is forced onto the overflow path.
  always_comb begin
    e_eff    = (E_IN == 8'd0) ? 8'd1 : E_IN;
    e_inc    = {1'b0, e_eff} + 9'd1;
    in_carry = M_SUM[27] || (E_IN == 8'hFF);
    in_zero  = (M_SUM == 28'd0);
    m_carry  = {M_SUM[27:2], M_SUM[1] | M_SUM[0]};
  end

  // One shift step: k = min(leading zeros, STEP, e-1) so the exponent never drops below 1.
  always_comb begin
    lz   = lzc(m);
    e_m1 = e - 8'd1;
    k    = lz;
    if (k > STEP_W) begin
      k = STEP_W;
    end else begin
      k = lz;
    end
    if ({3'b000, k} > e_m1) begin
      k = e_m1[4:0];
    end else begin
      k = k;
    end
    m_sh       = m << k;
    e_sh       = e - {3'b000, k};
    shift_exit = m_sh[26] || (e_sh == 8'd1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_carry || in_zero) state_next = DONE;
          else                     state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (shift_exit) state_next = DONE;
        else            state_next = SHIFT;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m         <= 27'd0;
      e         <= 8'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      S         <= 1'b0;
      E_NORM    <= 8'd0;
      M_NORM    <= 27'd0;
      ZERO      <= 1'b0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            S        <= S_IN;
            ZERO     <= 1'b0;
            OVF      <= 1'b0;
            UNF      <= 1'b0;
            m        <= M_SUM[26:0];
            e        <= e_eff;
            if (in_carry) begin
              out_valid <= 1'b1;
              if (e_inc >= 9'd255) begin
                OVF    <= 1'b1;
                E_NORM <= 8'hFF;
                M_NORM <= 27'd0;
              end else begin
                E_NORM <= e_inc[7:0];
                M_NORM <= m_carry;
              end
            end else if (in_zero) begin
              out_valid <= 1'b1;
              ZERO      <= 1'b1;
              E_NORM    <= 8'd0;
              M_NORM    <= 27'd0;
            end else begin
              out_valid <= 1'b0;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          m <= m_sh;
          e <= e_sh;
          if (shift_exit) begin
            out_valid <= 1'b1;
            M_NORM    <= m_sh;
            if (m_sh[26]) begin
              E_NORM <= e_sh;
            end else begin
              E_NORM <= 8'd0;
              UNF    <= 1'b1;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// Directed self-checking bench for fp_normalize (STEP=4).
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S_IN;
  logic [7:0]  E_IN;
  logic [27:0] M_SUM;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [7:0]  E_NORM;
  logic [26:0] M_NORM;
  logic        ZERO;
  logic        OVF;
  logic        UNF;

  int checks = 0;
  int errors = 0;
  int lat;

  fp_normalize #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S_IN(S_IN), .E_IN(E_IN), .M_SUM(M_SUM), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .E_NORM(E_NORM), .M_NORM(M_NORM),
    .ZERO(ZERO), .OVF(OVF), .UNF(UNF)
  );

  always #5 clk = ~clk;

  // Present one operand, return cycles from accept edge (counted as 1) to out_valid.
  task automatic start_op(input logic s, input logic [7:0] e, input logic [27:0] m, output int l);
    @(negedge clk);
    in_valid = 1'b1; S_IN = s; E_IN = e; M_SUM = m;
    @(posedge clk); #1;
    in_valid = 1'b0; S_IN = 1'b0; E_IN = 8'd0; M_SUM = 28'd0;
    l = 1;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S_IN = 1'b0; E_IN = 8'd0; M_SUM = 28'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({S, E_NORM, M_NORM, ZERO, OVF, UNF} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {S, E_NORM, M_NORM, ZERO, OVF, UNF}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_carry;
    start_op(1'b1, 8'd100, 28'h8000003, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL carry_latency got %0d exp 1", lat); end
    checks++; if (M_NORM !== 27'h4000001) begin errors++; $display("FAIL carry_m got %h exp 4000001", M_NORM); end
    checks++; if (E_NORM !== 8'd101) begin errors++; $display("FAIL carry_e got %0d exp 101", E_NORM); end
    checks++; if ({ZERO, OVF, UNF} !== 3'b000) begin errors++; $display("FAIL carry_flags got %b exp 000", {ZERO, OVF, UNF}); end
    checks++; if (S !== 1'b1) begin errors++; $display("FAIL carry_sign got %b exp 1", S); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL carry_in_ready got %b exp 0", in_ready); end
    release_op();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL carry_handshake got %b exp 10", {in_ready, out_valid}); end
  endtask

  task automatic test_passthrough;
    start_op(1'b0, 8'd50, 28'h4000005, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL pass_latency got %0d exp 2", lat); end
    checks++; if (M_NORM !== 27'h4000005) begin errors++; $display("FAIL pass_m got %h exp 4000005", M_NORM); end
    checks++; if (E_NORM !== 8'd50) begin errors++; $display("FAIL pass_e got %0d exp 50", E_NORM); end
    checks++; if (S !== 1'b0) begin errors++; $display("FAIL pass_sign got %b exp 0", S); end
    release_op();
  endtask

  task automatic test_cancel;
    start_op(1'b0, 8'd100, 28'h0000008, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL cancel_latency got %0d exp 7", lat); end
    checks++; if (M_NORM !== 27'h4000000) begin errors++; $display("FAIL cancel_m got %h exp 4000000", M_NORM); end
    checks++; if (E_NORM !== 8'd77) begin errors++; $display("FAIL cancel_e got %0d exp 77", E_NORM); end
    checks++; if ({ZERO, OVF, UNF} !== 3'b000) begin errors++; $display("FAIL cancel_flags got %b exp 000", {ZERO, OVF, UNF}); end
    release_op();
    // exactly STEP leading zeros: one shift cycle
    start_op(1'b0, 8'd20, 28'h0400000, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL step4_latency got %0d exp 2", lat); end
    checks++; if ({E_NORM, M_NORM} !== {8'd16, 27'h4000000}) begin
      errors++; $display("FAIL step4_result got %h/%h exp 10/4000000", E_NORM, M_NORM); end
    release_op();
  endtask

  task automatic test_clamp;
    start_op(1'b0, 8'd10, 28'h0000008, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL clamp_latency got %0d exp 4", lat); end
    checks++; if (M_NORM !== 27'h0001000) begin errors++; $display("FAIL clamp_m got %h exp 0001000", M_NORM); end
    checks++; if (E_NORM !== 8'd0) begin errors++; $display("FAIL clamp_e got %0d exp 0", E_NORM); end
    checks++; if ({ZERO, OVF, UNF} !== 3'b001) begin errors++; $display("FAIL clamp_flags got %b exp 001", {ZERO, OVF, UNF}); end
    release_op();
    // E_IN=0 behaves as exponent 1: no shift possible, denormal
    start_op(1'b0, 8'd0, 28'h2000000, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL e0_latency got %0d exp 2", lat); end
    checks++; if ({E_NORM, M_NORM, UNF} !== {8'd0, 27'h2000000, 1'b1}) begin
      errors++; $display("FAIL e0_result got %h/%h/%b exp 0/2000000/1", E_NORM, M_NORM, UNF); end
    release_op();
  endtask

  task automatic test_zero_ovf;
    start_op(1'b0, 8'd77, 28'h0000000, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d exp 1", lat); end
    checks++; if ({ZERO, OVF, UNF, E_NORM, M_NORM} !== {3'b100, 8'd0, 27'd0}) begin
      errors++; $display("FAIL zero_result got %b/%h/%h exp 100/0/0", {ZERO, OVF, UNF}, E_NORM, M_NORM); end
    release_op();
    start_op(1'b0, 8'd254, 28'h8000000, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d exp 1", lat); end
    checks++; if ({ZERO, OVF, UNF} !== 3'b010) begin errors++; $display("FAIL ovf_flags got %b exp 010", {ZERO, OVF, UNF}); end
    checks++; if ({E_NORM, M_NORM} !== {8'hFF, 27'd0}) begin
      errors++; $display("FAIL ovf_result got %h/%h exp ff/0", E_NORM, M_NORM); end
    release_op();
    start_op(1'b0, 8'd253, 28'h8000000, lat);
    checks++; if ({OVF, E_NORM, M_NORM} !== {1'b0, 8'd254, 27'h4000000}) begin
      errors++; $display("FAIL no_ovf_result got %b/%h/%h exp 0/fe/4000000", OVF, E_NORM, M_NORM); end
    release_op();
  endtask

  task automatic test_backpressure;
    start_op(1'b1, 8'd50, 28'h4000005, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; S_IN = 1'b0; E_IN = 8'd9; M_SUM = 28'h8000000;
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, S, E_NORM, M_NORM, ZERO, OVF, UNF} !== {3'b101, 8'd50, 27'h4000005, 3'b000}) begin
        errors++; $display("FAIL hold_cycle%0d got %b%b%b/%h/%h exp 101/32/4000005", i, out_valid, in_ready, S, E_NORM, M_NORM); end
    end
    in_valid = 1'b0;
    release_op();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL hold_release got %b exp 10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1; S_IN = 1'b1; E_IN = 8'd100; M_SUM = 28'h0000008;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_hs got %b exp 10", {in_ready, out_valid}); end
    checks++; if ({S, E_NORM, M_NORM, ZERO, OVF, UNF} !== 39'd0) begin
      errors++; $display("FAIL midrst_outputs got %h exp 0", {S, E_NORM, M_NORM, ZERO, OVF, UNF}); end
    @(negedge clk); rst = 1'b0;
    start_op(1'b0, 8'd100, 28'h8000003, lat);
    checks++; if ({lat == 1, E_NORM, M_NORM, S} !== {1'b1, 8'd101, 27'h4000001, 1'b0}) begin
      errors++; $display("FAIL midrst_fresh got lat%0d %h/%h/%b exp lat1 65/4000001/0", lat, E_NORM, M_NORM, S); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_carry();
    test_passthrough();
    test_cancel();
    test_clamp();
    test_zero_ovf();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
